// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefLenWidth  = 16;

    // Width of a requester index; never zero, even for a single requester.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request found after last_owner, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    // Scan requesters from last_owner+1 upward; the owner just served is checked last.
    always_comb begin
        int unsigned        idx;
        logic [IDX_W-1:0]   idx_s;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        idx_s   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx   = (32'(last_owner) + i) % NUM_REQ;
            idx_s = IDX_W'(idx);
            if (!any && req[idx_s]) begin
                any          = 1'b1;
                gnt[idx_s]   = 1'b1;
                gnt_idx      = idx_s;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter feeding one async-FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned LEN_WIDTH  = DefLenWidth
) (
    input  logic                          wr_clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [LEN_WIDTH-1:0]          frame_len_o,
    output logic                          frame_done_o
);

    localparam int unsigned IdxW = idx_width(NUM_REQ);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q;
    logic [IdxW-1:0]       owner_q;
    logic [IdxW-1:0]       last_owner_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic [LEN_WIDTH-1:0]  frame_len_q;
    logic [LEN_WIDTH-1:0]  beat_inc;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_any;

    logic                  busy;
    logic                  transfer;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_pick (
        .req        (req_valid_i),
        .last_owner (last_owner_q),
        .gnt        (pick_gnt),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    // Split the flat data bus into per-requester words.
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            req_words[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Saturating beat count including the current beat.
    always_comb begin
        beat_inc = (beat_q == '1) ? beat_q : beat_q + LEN_WIDTH'(1);
    end

    // State register.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on any request, leave BUSY on the last accepted beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_any) state_d = StBusy;
            StBusy:  if (last_beat) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        busy           = (state_q == StBusy) && !rst_i;
        req_ready_o    = '0;
        transfer       = 1'b0;
        last_beat      = 1'b0;
        fifo_wr_data_o = '0;
        if (busy) begin
            req_ready_o[owner_q] = ~fifo_full_i;
            transfer             = req_valid_i[owner_q] & ~fifo_full_i;
            last_beat            = transfer & req_last_i[owner_q];
            fifo_wr_data_o       = req_words[owner_q];
        end
        fifo_wr_en_o = transfer;
        frame_done_o = last_beat;
        grant_o      = grant_q;
        frame_len_o  = frame_len_q;
    end

    // Ownership, round-robin pointer, beat counter and completed-frame length.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IdxW'(NUM_REQ - 1);
            beat_q       <= '0;
            frame_len_q  <= '0;
        end else if (state_q == StIdle) begin
            if (pick_any) begin
                grant_q <= pick_gnt;
                owner_q <= pick_idx;
                beat_q  <= '0;
            end
        end else if (transfer) begin
            beat_q <= beat_inc;
            if (last_beat) begin
                frame_len_q  <= beat_inc;
                last_owner_q <= owner_q;
                grant_q      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: one table of per-cycle vectors plus hand-written corner sequences.
module tb_fifo_wr_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned DataW  = 8;
    localparam int unsigned LenW   = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NumReq-1:0]        valid = '0;
    logic [NumReq*DataW-1:0]  data = '0;
    logic [NumReq-1:0]        last = '0;
    logic                     full = 1'b0;
    logic [NumReq-1:0]        ready;
    logic                     wr_en;
    logic [DataW-1:0]         wr_data;
    logic [NumReq-1:0]        grant;
    logic [LenW-1:0]          frame_len;
    logic                     frame_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NumReq),
        .DATA_WIDTH (DataW),
        .LEN_WIDTH  (LenW)
    ) dut (
        .wr_clk_i       (clk),
        .rst_i          (rst),
        .req_valid_i    (valid),
        .req_data_i     (data),
        .req_last_i     (last),
        .req_ready_o    (ready),
        .fifo_full_i    (full),
        .fifo_wr_en_o   (wr_en),
        .fifo_wr_data_o (wr_data),
        .grant_o        (grant),
        .frame_len_o    (frame_len),
        .frame_done_o   (frame_done)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [31:0] data;
        logic [3:0]  e_grant;
        logic [3:0]  e_ready;
        logic        e_wr;
        logic [7:0]  e_data;
        logic        e_done;
        logic [3:0]  e_len;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic [3:0] vl, logic [3:0] ls, logic f,
                               logic [31:0] d, logic [3:0] g, logic [3:0] rd,
                               logic wr, logic [7:0] wd, logic dn, logic [3:0] ln);
        vec_t x;
        x.rst = r; x.valid = vl; x.last = ls; x.full = f; x.data = d;
        x.e_grant = g; x.e_ready = rd; x.e_wr = wr; x.e_data = wd;
        x.e_done = dn; x.e_len = ln;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic step(logic r, logic [3:0] vl, logic [3:0] ls, logic f, logic [31:0] d);
        @(negedge clk);
        rst = r; valid = vl; last = ls; full = f; data = d;
        #1;
    endtask

    task automatic expect_out(string tag, logic [3:0] g, logic [3:0] rd, logic wr,
                              logic [7:0] wd, logic dn, logic [3:0] ln);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".ready"}, 32'(ready), 32'(rd));
        check({tag, ".wr_en"}, 32'(wr_en), 32'(wr));
        check({tag, ".wr_data"}, 32'(wr_data), 32'(wd));
        check({tag, ".done"}, 32'(frame_done), 32'(dn));
        check({tag, ".len"}, 32'(frame_len), 32'(ln));
    endtask

    initial begin
        // Two 3-beat frames from requesters 0 and 2.
        tbl.push_back(v(1, 4'b0000, 4'b0000, 0, 32'h0,         4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 4'b0101, 4'b0000, 0, 32'h0021_0001, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 4'b0101, 4'b0000, 0, 32'h0021_0001, 4'b0001, 4'b0001, 1, 8'h01, 0, 0));
        tbl.push_back(v(0, 4'b0101, 4'b0000, 0, 32'h0021_0002, 4'b0001, 4'b0001, 1, 8'h02, 0, 0));
        tbl.push_back(v(0, 4'b0101, 4'b0001, 0, 32'h0021_0003, 4'b0001, 4'b0001, 1, 8'h03, 1, 0));
        tbl.push_back(v(0, 4'b0101, 4'b0000, 0, 32'h0021_0004, 4'b0000, 4'b0000, 0, 8'h00, 0, 3));
        tbl.push_back(v(0, 4'b0101, 4'b0000, 0, 32'h0021_0004, 4'b0100, 4'b0100, 1, 8'h21, 0, 3));
        tbl.push_back(v(0, 4'b0101, 4'b0000, 0, 32'h0022_0004, 4'b0100, 4'b0100, 1, 8'h22, 0, 3));
        tbl.push_back(v(0, 4'b0101, 4'b0100, 0, 32'h0023_0004, 4'b0100, 4'b0100, 1, 8'h23, 1, 3));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 0, 32'h0,         4'b0000, 4'b0000, 0, 8'h00, 0, 3));
        // All requesters busy with single-beat frames: order 0,1,2,3,0.
        tbl.push_back(v(1, 4'b0000, 4'b0000, 0, 32'h0,         4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0001, 4'b0001, 1, 8'hA0, 1, 0));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0010, 4'b0010, 1, 8'hA1, 1, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0100, 4'b0100, 1, 8'hA2, 1, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b1000, 4'b1000, 1, 8'hA3, 1, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(v(0, 4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0001, 4'b0001, 1, 8'hA0, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].valid, tbl[i].last, tbl[i].full, tbl[i].data);
            expect_out($sformatf("row%0d", i), tbl[i].e_grant, tbl[i].e_ready, tbl[i].e_wr,
                       tbl[i].e_data, tbl[i].e_done, tbl[i].e_len);
        end

        // FIFO full for 5 cycles mid-frame; valid returns together with room.
        step(1, 4'b0000, 4'b0000, 0, 32'h0);
        step(0, 4'b0010, 4'b0000, 0, 32'h5100);
        expect_out("full.idle", 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        step(0, 4'b0010, 4'b0000, 0, 32'h5100);
        expect_out("full.b1", 4'b0010, 4'b0010, 1, 8'h51, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, (i < 3) ? 4'b0010 : 4'b0000, 4'b0000, 1, 32'h5200);
            expect_out($sformatf("full.stall%0d", i), 4'b0010, 4'b0000, 0, 8'h52, 0, 0);
        end
        step(0, 4'b0010, 4'b0000, 0, 32'h5200);
        expect_out("full.b2", 4'b0010, 4'b0010, 1, 8'h52, 0, 0);
        step(0, 4'b0010, 4'b0010, 0, 32'h5300);
        expect_out("full.b3", 4'b0010, 4'b0010, 1, 8'h53, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 32'h0);
        expect_out("full.len", 4'b0000, 4'b0000, 0, 8'h00, 0, 3);

        // Owner stalls while requester 1 waits; grant is held.
        step(1, 4'b0000, 4'b0000, 0, 32'h0);
        step(0, 4'b0011, 4'b0000, 0, 32'h0000_1101);
        expect_out("stall.idle", 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        step(0, 4'b0011, 4'b0000, 0, 32'h0000_1101);
        expect_out("stall.b1", 4'b0001, 4'b0001, 1, 8'h01, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0010, 4'b0000, 0, 32'h0000_1102);
            expect_out($sformatf("stall.hold%0d", i), 4'b0001, 4'b0001, 0, 8'h02, 0, 0);
        end
        step(0, 4'b0011, 4'b0001, 0, 32'h0000_1102);
        expect_out("stall.b2", 4'b0001, 4'b0001, 1, 8'h02, 1, 0);
        step(0, 4'b0010, 4'b0000, 0, 32'h0000_1100);
        expect_out("stall.idle2", 4'b0000, 4'b0000, 0, 8'h00, 0, 2);
        step(0, 4'b0010, 4'b0010, 0, 32'h0000_1100);
        expect_out("stall.r1", 4'b0010, 4'b0010, 1, 8'h11, 1, 2);

        // Reset on the 2nd beat of requester 1's frame; afterwards requester 0 wins.
        step(1, 4'b0000, 4'b0000, 0, 32'h0);
        step(0, 4'b0001, 4'b0001, 0, 32'h0000_0001);
        step(0, 4'b0001, 4'b0001, 0, 32'h0000_0001);
        expect_out("rst.r0", 4'b0001, 4'b0001, 1, 8'h01, 1, 0);
        step(0, 4'b0010, 4'b0000, 0, 32'h0000_0100);
        expect_out("rst.idle", 4'b0000, 4'b0000, 0, 8'h00, 0, 1);
        step(0, 4'b0010, 4'b0000, 0, 32'h0000_0100);
        expect_out("rst.b1", 4'b0010, 4'b0010, 1, 8'h01, 0, 1);
        step(1, 4'b0010, 4'b0000, 0, 32'h0000_0200);
        expect_out("rst.abort", 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        step(0, 4'b0011, 4'b0000, 0, 32'h0000_0207);
        expect_out("rst.rel", 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        step(0, 4'b0011, 4'b0000, 0, 32'h0000_0207);
        expect_out("rst.prio", 4'b0001, 4'b0001, 1, 8'h07, 0, 0);

        // 18-beat frame saturates the 4-bit length at 15.
        step(1, 4'b0000, 4'b0000, 0, 32'h0);
        step(0, 4'b0100, 4'b0000, 0, 32'h0);
        expect_out("sat.idle", 4'b0000, 4'b0000, 0, 8'h00, 0, 0);
        for (int b = 1; b <= 18; b++) begin
            step(0, 4'b0100, (b == 18) ? 4'b0100 : 4'b0000, 0, 32'(b) << 16);
            expect_out($sformatf("sat.b%0d", b), 4'b0100, 4'b0100, 1, 8'(b), (b == 18), 0);
        end
        step(0, 4'b0000, 4'b0000, 0, 32'h0);
        expect_out("sat.len", 4'b0000, 4'b0000, 0, 8'h00, 0, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one async-FIFO write port (2..8).
REQ-002 Parameter DATA_WIDTH, default 8: FIFO word width.
REQ-003 Parameter LEN_WIDTH, default 16: frame beat-counter width.
REQ-004 wr_clk_i  in  1  write-domain clock; single clock, all logic on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous assert, active-high.
REQ-006 req_valid_i  in  NUM_REQ  per-requester word valid.
REQ-007 req_data_i  in  NUM_REQ*DATA_WIDTH  per-requester word; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last_i  in  NUM_REQ  per-requester end-of-frame marker, qualified by valid.
REQ-009 req_ready_o  out  NUM_REQ  per-requester accept.
REQ-010 fifo_full_i  in  1  FIFO write-side full flag.
REQ-011 fifo_wr_en_o  out  1  FIFO write enable.
REQ-012 fifo_wr_data_o  out  DATA_WIDTH  FIFO write data.
REQ-013 grant_o  out  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-014 frame_len_o  out  LEN_WIDTH  beats written for the last completed frame.
REQ-015 frame_done_o  out  1  one-cycle pulse on the last beat of each frame.

Function
REQ-016 FSM states SHALL be IDLE and BUSY.
REQ-017 IDLE: if any req_valid_i is set, select owner round-robin, searching from (last_owner+1) mod NUM_REQ upward; register owner into grant_o; go to BUSY next cycle.
REQ-018 IDLE with no valid: stay; grant_o = 0; all req_ready_o = 0.
REQ-019 BUSY: req_ready_o[owner] = ~fifo_full_i (combinational); every other ready bit = 0.
REQ-020 Transfer = req_valid_i[owner] & req_ready_o[owner]; fifo_wr_en_o SHALL equal transfer in the same cycle; no write is ever issued while fifo_full_i = 1.
REQ-021 fifo_wr_data_o SHALL be the owner's req_data_i, muxed combinationally; value is 0 when no owner is active.
REQ-022 Grant is held for a whole frame; owner dropping valid mid-frame stalls the arbiter; the grant is not revoked.
REQ-023 Transfer with req_last_i[owner] = 1: pulse frame_done_o; load frame_len_o with beat count including this beat; set last_owner = owner; return to IDLE.
REQ-024 Beat counter clears on entry to BUSY, increments per transfer, and saturates at all-ones (no wrap).
REQ-025 Arbitration costs exactly one IDLE cycle between frames; a requester re-arbitrates even if it was the only one requesting.
REQ-026 Simultaneous full deassert and valid assert: transfer occurs in that cycle.
REQ-027 Single-beat frame (valid and last on the first BUSY cycle) is legal: frame_len_o = 1.

Reset
REQ-028 On rst_i: state = IDLE, grant_o = 0, last_owner = NUM_REQ-1 (requester 0 first), beat counter = 0, frame_len_o = 0, frame_done_o = 0.
REQ-029 Reset mid-frame SHALL abort without a trailing write; fifo_wr_en_o = 0 and req_ready_o = 0 while reset is asserted.

Structure
REQ-030 Shared package fifo_arb_pkg SHALL hold the state enum and the default parameter constants.
REQ-031 Round-robin selection SHALL live in one combinational sub-module, rr_pick (request vector, last owner -> one-hot grant).

Verification
REQ-032 Reset release, requesters 0 and 2 both send a 3-beat frame -> owner 0 first (len 3), then owner 2 (len 3), each preceded by one IDLE cycle.
REQ-033 All four requesters continuously valid, 1-beat frames -> grant order 0,1,2,3,0, and frame_done_o pulses every 2 cycles.
REQ-034 fifo_full_i held high for 5 cycles mid-frame -> fifo_wr_en_o = 0 and ready = 0 during those cycles; no data loss; frame_len_o counts only accepted beats.
REQ-035 Owner drops valid 3 cycles mid-frame while requester 1 is valid -> grant held; requester 1 ready stays 0.
REQ-036 rst_i asserted on the 2nd beat of a 4-beat frame -> immediate grant_o = 0 and fifo_wr_en_o = 0; after release, requester 0 has priority.
REQ-037 Frame of 2^LEN_WIDTH+2 beats (LEN_WIDTH = 4) -> frame_len_o = 15, saturated.
